// File: rtl/l2_arbiter.sv
// rtl/l2_arbiter.sv - Grants the single L2 port to icache or dcache and muxes the owner's request.
// Optional L2_ARB_RR_EN: round-robin on ties; default build gives dcache priority.
module l2_arbiter #(
    parameter int ADDR_W   = 28,
    parameter int TURN_CYC = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              irq,
    input  logic [ADDR_W-1:0] ic_l2_addr,
    input  logic              ic_rw,
    input  logic              drq,
    input  logic [ADDR_W-1:0] dc_l2_addr,
    input  logic              dc_rw,
    output logic              ic_en,
    output logic              dc_en,
    output logic              l2_req,
    output logic [ADDR_W-1:0] l2_addr,
    output logic              l2_rw,
    output logic              last_owner
);

    localparam int CNT_W = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_IC   = 2'd1,
        ARB_DC   = 2'd2,
        ARB_TURN = 2'd3
    } arb_state_t;

    arb_state_t       state, state_next;
    logic [CNT_W-1:0] turn_cnt, cnt_next;
    logic             last_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ARB_IDLE;
            turn_cnt   <= '0;
            last_owner <= 1'b0;
        end else begin
            state      <= state_next;
            turn_cnt   <= cnt_next;
            last_owner <= last_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = turn_cnt;
        last_next  = last_owner;
        case (state)
            ARB_IDLE: begin
                if (irq && drq) begin
`ifdef L2_ARB_RR_EN
                    if (last_owner) begin
                        state_next = ARB_IC;
                        last_next  = 1'b0;
                    end else begin
                        state_next = ARB_DC;
                        last_next  = 1'b1;
                    end
`else
                    state_next = ARB_DC;
                    last_next  = 1'b1;
`endif
                end else if (irq) begin
                    state_next = ARB_IC;
                    last_next  = 1'b0;
                end else if (drq) begin
                    state_next = ARB_DC;
                    last_next  = 1'b1;
                end
            end
            ARB_IC: begin
                if (!irq) begin
                    state_next = ARB_TURN;
                    cnt_next   = CNT_W'(TURN_CYC - 1);
                end
            end
            ARB_DC: begin
                if (!drq) begin
                    state_next = ARB_TURN;
                    cnt_next   = CNT_W'(TURN_CYC - 1);
                end
            end
            ARB_TURN: begin
                // Requests are deliberately not looked at until the bus has been quiet long enough.
                if (turn_cnt == '0) begin
                    state_next = ARB_IDLE;
                end else begin
                    cnt_next = turn_cnt - 1'b1;
                end
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    always_comb begin
        ic_en   = (state == ARB_IC);
        dc_en   = (state == ARB_DC);
        l2_req  = (ic_en & irq) | (dc_en & drq);
        l2_addr = '0;
        l2_rw   = 1'b0;
        if (ic_en) begin
            l2_addr = ic_l2_addr;
            l2_rw   = ic_rw;
        end else if (dc_en) begin
            l2_addr = dc_l2_addr;
            l2_rw   = dc_rw;
        end
    end

endmodule
